matmul_par: RTL and testbench

MATMUL_PAR -- requirements
Module: matmul_par

---
 rtl/matmul_par.sv | 246 ++++++++++++++++++++++++
 tb/tb_matmul_par.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_par.sv
// matmul_par: computes C = A*B one C element at a time over a single shared
// memory port. Each element streams A[i][k] / B[k][j] read pairs, multiplies
// the low PREC bits of each word and accumulates, then writes C[i][j].
// Optional build macro MATMUL_PAR_ACC_EN enables accumulate mode (C = C + A*B),
// which reads the old C element before writing it back.
module matmul_par #(
  parameter int MEM_AW   = 16,
  parameter int MEM_DW   = 32,
  parameter int DIM_BITS = 16,
  parameter int PREC     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sm_ena,
  input  logic                go,
  input  logic                acc_mode,
  output logic                busy,
  output logic                done,
  input  logic [MEM_AW-1:0]   aBASE,
  input  logic [MEM_AW-1:0]   bBASE,
  input  logic [MEM_AW-1:0]   cBASE,
  input  logic [DIM_BITS-1:0] aSTRIDE,
  input  logic [DIM_BITS-1:0] bSTRIDE,
  input  logic [DIM_BITS-1:0] cSTRIDE,
  input  logic [DIM_BITS-1:0] aROWS,
  input  logic [DIM_BITS-1:0] aCOLS,
  input  logic [DIM_BITS-1:0] bCOLS,
  output logic                mem_req,
  output logic                mem_write,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic                mem_rdata_vld,
  input  logic [MEM_DW-1:0]   mem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE_A, S_ISSUE_B, S_DRAIN, S_RD_C, S_WAIT_C, S_WR_C, S_NEXT, S_DONE
  } state_t;

  localparam logic [MEM_AW-1:0]   ADDR_ONE = MEM_AW'(1);
  localparam logic [DIM_BITS-1:0] DIM_ONE  = DIM_BITS'(1);

  state_t state, state_nxt;

  // Latched operation parameters
  logic [DIM_BITS-1:0] a_stride_r, b_stride_r, c_stride_r;
  logic [DIM_BITS-1:0] rows_r, cols_r, ncols_r;
  logic [MEM_AW-1:0]   b_base_r;

  // Loop counters and incremental address pointers
  logic [DIM_BITS-1:0] i_cnt, j_cnt, k_cnt;
  logic [MEM_AW-1:0]   a_row, a_ptr, b_col, b_ptr, c_row, c_ptr;

  // Read-return datapath
  logic [PREC-1:0]     a_word;
  logic [MEM_DW-1:0]   acc;
  logic [DIM_BITS:0]   ret_cnt;
  logic [DIM_BITS:0]   ret_total;
  logic [DIM_BITS:0]   pend;
  logic [MEM_DW-1:0]   wr_data;

  logic dims_zero, last_i, last_j, last_k;
  logic issue_rd, take, elem_start, acc_en;

  // Wrapping address step by a stride (modulo 2^MEM_AW).
  function automatic logic [MEM_AW-1:0] addr_add(input logic [MEM_AW-1:0] base,
                                                 input logic [DIM_BITS-1:0] step);
    return base + MEM_AW'(step);
  endfunction

  // Unsigned multiply-accumulate, wrapping modulo 2^MEM_DW.
  function automatic logic [MEM_DW-1:0] mac(input logic [MEM_DW-1:0] acc_in,
                                            input logic [PREC-1:0]   x,
                                            input logic [PREC-1:0]   y);
    logic [2*PREC-1:0] prod;
    prod = {{PREC{1'b0}}, x} * {{PREC{1'b0}}, y};
    return acc_in + MEM_DW'(prod);
  endfunction

  assign dims_zero = (aROWS == '0) || (aCOLS == '0) || (bCOLS == '0);
  assign last_i    = (i_cnt == rows_r - DIM_ONE);
  assign last_j    = (j_cnt == ncols_r - DIM_ONE);
  assign last_k    = (k_cnt == cols_r - DIM_ONE);
  assign ret_total = {cols_r, 1'b0};
  assign issue_rd  = mem_req && !mem_write;
  // Returns are only accepted against reads this run actually issued, so
  // data still in flight from before a reset is dropped.
  assign take       = mem_rdata_vld && (pend != '0);
  assign elem_start = sm_ena && (((state == S_IDLE) && go) || (state == S_NEXT));
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

`ifdef MATMUL_PAR_ACC_EN
  logic              acc_en_r;
  logic [MEM_DW-1:0] c_word;
  logic              c_got;
  assign acc_en  = acc_en_r;
  assign wr_data = acc_en_r ? (acc + c_word) : acc;
`else
  logic unused_inputs;
  assign acc_en        = 1'b0;
  assign wr_data       = acc;
  assign unused_inputs = ^{acc_mode, mem_rdata[MEM_DW-1:PREC]};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and memory-port decode; nothing moves and no access is issued while sm_ena=0
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sm_ena) begin
      case (state)
        S_IDLE:    if (go) state_nxt = dims_zero ? S_DONE : S_ISSUE_A;
        S_ISSUE_A: begin
          mem_req   = 1'b1;
          mem_addr  = a_ptr;
          state_nxt = S_ISSUE_B;
        end
        S_ISSUE_B: begin
          mem_req   = 1'b1;
          mem_addr  = b_ptr;
          state_nxt = last_k ? S_DRAIN : S_ISSUE_A;
        end
        S_DRAIN:   if (ret_cnt == ret_total) state_nxt = acc_en ? S_RD_C : S_WR_C;
`ifdef MATMUL_PAR_ACC_EN
        S_RD_C: begin
          mem_req   = 1'b1;
          mem_addr  = c_ptr;
          state_nxt = S_WAIT_C;
        end
        S_WAIT_C:  if (c_got) state_nxt = S_WR_C;
`endif
        S_WR_C: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          mem_addr  = c_ptr;
          mem_wdata = wr_data;
          state_nxt = S_NEXT;
        end
        S_NEXT:    state_nxt = (last_i && last_j) ? S_DONE : S_ISSUE_A;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // Configuration latch, loop counters and incremental address generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stride_r <= '0; b_stride_r <= '0; c_stride_r <= '0;
      rows_r     <= '0; cols_r     <= '0; ncols_r    <= '0;
      b_base_r   <= '0;
      i_cnt      <= '0; j_cnt      <= '0; k_cnt      <= '0;
      a_row      <= '0; a_ptr      <= '0; b_col      <= '0;
      b_ptr      <= '0; c_row      <= '0; c_ptr      <= '0;
`ifdef MATMUL_PAR_ACC_EN
      acc_en_r   <= 1'b0;
`endif
    end else if (sm_ena) begin
      case (state)
        S_IDLE: if (go) begin
          a_stride_r <= aSTRIDE; b_stride_r <= bSTRIDE; c_stride_r <= cSTRIDE;
          rows_r     <= aROWS;   cols_r     <= aCOLS;   ncols_r    <= bCOLS;
          b_base_r   <= bBASE;
          i_cnt      <= '0; j_cnt <= '0; k_cnt <= '0;
          a_row      <= aBASE; a_ptr <= aBASE;
          b_col      <= bBASE; b_ptr <= bBASE;
          c_row      <= cBASE; c_ptr <= cBASE;
`ifdef MATMUL_PAR_ACC_EN
          acc_en_r   <= acc_mode;
`endif
        end
        S_ISSUE_A: a_ptr <= a_ptr + ADDR_ONE;
        S_ISSUE_B: begin
          b_ptr <= addr_add(b_ptr, b_stride_r);
          k_cnt <= last_k ? '0 : k_cnt + DIM_ONE;
        end
        S_NEXT: begin
          if (last_j) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + DIM_ONE;
            a_row <= addr_add(a_row, a_stride_r);
            a_ptr <= addr_add(a_row, a_stride_r);
            b_col <= b_base_r;
            b_ptr <= b_base_r;
            c_row <= addr_add(c_row, c_stride_r);
            c_ptr <= addr_add(c_row, c_stride_r);
          end else begin
            j_cnt <= j_cnt + DIM_ONE;
            a_ptr <= a_row;
            b_col <= b_col + ADDR_ONE;
            b_ptr <= b_col + ADDR_ONE;
            c_ptr <= c_ptr + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-return capture: pairs A then B into the accumulator; runs regardless of sm_ena
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_word  <= '0;
      acc     <= '0;
      ret_cnt <= '0;
      pend    <= '0;
`ifdef MATMUL_PAR_ACC_EN
      c_word  <= '0;
      c_got   <= 1'b0;
`endif
    end else begin
      if (issue_rd && !take)      pend <= pend + 1'b1;
      else if (!issue_rd && take) pend <= pend - 1'b1;
      if (take) begin
        if (ret_cnt != ret_total) begin
          if (!ret_cnt[0]) a_word <= mem_rdata[PREC-1:0];
          else             acc    <= mac(acc, a_word, mem_rdata[PREC-1:0]);
          ret_cnt <= ret_cnt + 1'b1;
        end
`ifdef MATMUL_PAR_ACC_EN
        else begin
          c_word <= mem_rdata;
          c_got  <= 1'b1;
        end
`endif
      end
      if (elem_start) begin
        acc     <= '0;
        ret_cnt <= '0;
`ifdef MATMUL_PAR_ACC_EN
        c_got   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_matmul_par.sv
// Testbench for matmul_par: a behavioural memory with in-order, randomly
// delayed read returns, and a scoreboard of expected C writes computed from
// the bench's own copy of memory before each operation.
module tb_matmul_par;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int DB = 16;
  localparam int PR = 16;

  logic          clk, rst_n, sm_ena, go, acc_mode, busy, done;
  logic [AW-1:0] aBASE, bBASE, cBASE;
  logic [DB-1:0] aSTRIDE, bSTRIDE, cSTRIDE, aROWS, aCOLS, bCOLS;
  logic          mem_req, mem_write, mem_rdata_vld;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  matmul_par #(.MEM_AW(AW), .MEM_DW(DW), .DIM_BITS(DB), .PREC(PR)) dut (
    .clk(clk), .rst_n(rst_n), .sm_ena(sm_ena), .go(go), .acc_mode(acc_mode),
    .busy(busy), .done(done),
    .aBASE(aBASE), .bBASE(bBASE), .cBASE(cBASE),
    .aSTRIDE(aSTRIDE), .bSTRIDE(bSTRIDE), .cSTRIDE(cSTRIDE),
    .aROWS(aROWS), .aCOLS(aCOLS), .bCOLS(bCOLS),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int rdy; logic [DW-1:0] d; } rd_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  logic [DW-1:0] mem [int];
  rd_t rd_q [$];
  wr_t obs_q [$];
  wr_t exp_q [$];

  int checks = 0;
  int passed = 0;
  int cyc = 0, lat_max = 1, last_rdy = 0, lat_v, rdy_v;
  int req_cnt = 0, req_frozen = 0, done_rises = 0;
  logic done_q = 1'b0;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return '0;
  endfunction

  // Memory: observes requests mid-cycle, returns read data in order after 1..lat_max cycles
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rd_q.size() > 0 && rd_q[0].rdy <= cyc) begin
      mem_rdata_vld = 1'b1;
      mem_rdata     = rd_q[0].d;
      void'(rd_q.pop_front());
    end else begin
      mem_rdata_vld = 1'b0;
      mem_rdata     = $urandom;
    end
    if (mem_req) begin
      req_cnt = req_cnt + 1;
      if (!sm_ena) req_frozen = req_frozen + 1;
      if (mem_write) begin
        mem[int'(mem_addr)] = mem_wdata;
        obs_q.push_back('{mem_addr, mem_wdata});
      end else begin
        lat_v = int'($urandom_range(1, lat_max));
        rdy_v = cyc + lat_v;
        if (rdy_v <= last_rdy) rdy_v = last_rdy + 1;
        last_rdy = rdy_v;
        rd_q.push_back('{rdy_v, rd_word(mem_addr)});
      end
    end
    if (done && !done_q) done_rises = done_rises + 1;
    done_q = done;
  end

  // Reference model: pushes the expected C writes in row-major order
  task automatic model_op(input logic [AW-1:0] ab, bb, cb, input logic [DB-1:0] sa, sb, sc,
                          input logic [DB-1:0] r, k, n, input logic am);
    logic [AW-1:0] ca;
    logic [DW-1:0] s, av, bv;
    for (int i = 0; i < int'(r); i++)
      for (int j = 0; j < int'(n); j++) begin
        s = '0;
        for (int kk = 0; kk < int'(k); kk++) begin
          av = rd_word(AW'(int'(ab) + i * int'(sa) + kk));
          bv = rd_word(AW'(int'(bb) + kk * int'(sb) + j));
          s  = s + {16'h0, av[PR-1:0]} * {16'h0, bv[PR-1:0]};
        end
        ca = AW'(int'(cb) + i * int'(sc) + j);
`ifdef MATMUL_PAR_ACC_EN
        if (am) s = s + rd_word(ca);
`else
        if (am) s = s + '0;
`endif
        exp_q.push_back('{ca, s});
      end
  endtask

  task automatic launch(input logic [AW-1:0] ab, bb, cb, input logic [DB-1:0] sa, sb, sc,
                        input logic [DB-1:0] r, k, n, input logic am);
    @(posedge clk); #1;
    aBASE = ab; bBASE = bb; cBASE = cb;
    aSTRIDE = sa; bSTRIDE = sb; cSTRIDE = sc;
    aROWS = r; aCOLS = k; bCOLS = n; acc_mode = am; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    aBASE = AW'($urandom); bBASE = AW'($urandom); cBASE = AW'($urandom);
    aSTRIDE = DB'($urandom); bSTRIDE = DB'($urandom); cSTRIDE = DB'($urandom);
    aROWS = DB'($urandom); aCOLS = DB'($urandom); bCOLS = DB'($urandom);
    acc_mode = 1'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_2x2;
    mem[32'h100] = 1; mem[32'h101] = 2; mem[32'h102] = 3; mem[32'h103] = 4;
    mem[32'h200] = 5; mem[32'h201] = 6; mem[32'h202] = 7; mem[32'h203] = 8;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sm_ena = 1'b1; go = 1'b0; acc_mode = 1'b0;
    aBASE = '0; bBASE = '0; cBASE = '0; aSTRIDE = '0; bSTRIDE = '0; cSTRIDE = '0;
    aROWS = '0; aCOLS = '0; bCOLS = '0; mem_rdata_vld = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_req); else passed++;
    checks++; if (mem_write !== 1'b0) $display("FAIL reset_write: got %b want 0", mem_write); else passed++;
    checks++; if (mem_addr !== '0) $display("FAIL reset_addr: got %h want 0", mem_addr); else passed++;
    checks++; if (mem_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", mem_wdata); else passed++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_basic_2x2;
    int d0; bit ok; wr_t e, o;
    lat_max = 1;
    load_2x2();
    model_op(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    d0 = done_rises;
    launch(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    wait_done(300, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) $display("FAIL basic_timeout: done not seen"); else passed++;
    checks++; if (done_rises - d0 !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_rises - d0); else passed++;
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL basic_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d) $display("FAIL basic_write: got @%h=%0d want @%h=%0d", o.a, o.d, e.a, e.d);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random_latency;
    int d0; bit ok; wr_t e, o;
    lat_max = 6;
    model_op(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    d0 = done_rises;
    launch(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    aBASE = 16'h700; aCOLS = 16'd1; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    wait_done(400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) $display("FAIL rlat_timeout: done not seen"); else passed++;
    checks++; if (done_rises - d0 !== 1) $display("FAIL rlat_done_pulses: got %0d want 1", done_rises - d0); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rlat_busy_after: got %b want 0", busy); else passed++;
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rlat_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d) $display("FAIL rlat_write: got @%h=%0d want @%h=%0d", o.a, o.d, e.a, e.d);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_acc_mode;
    bit ok; wr_t e, o;
    lat_max = 2;
    for (int a = 16'h300; a < 16'h304; a++) mem[a] = 100;
    model_op(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b1);
    launch(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b1);
    wait_done(400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) $display("FAIL acc_timeout: done not seen"); else passed++;
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL acc_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d) $display("FAIL acc_write: got @%h=%0d want @%h=%0d", o.a, o.d, e.a, e.d);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zero_dim;
    int r0;
    logic [DB-1:0] r, k, n;
    for (int z = 0; z < 3; z++) begin
      r = (z == 0) ? 16'd0 : 16'd2;
      k = (z == 1) ? 16'd0 : 16'd2;
      n = (z == 2) ? 16'd0 : 16'd2;
      r0 = req_cnt;
      launch(16'h100, 16'h200, 16'h300, 2, 2, 2, r, k, n, 1'b0);
      checks++; if (done !== 1'b1) $display("FAIL zero%0d_done_high: got %b want 1", z, done); else passed++;
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero%0d_back_idle: got done=%b busy=%b want 0 0", z, done, busy); else passed++;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_cnt - r0 !== 0) $display("FAIL zero%0d_no_req: got %0d want 0", z, req_cnt - r0); else passed++;
    end
    obs_q.delete();
  endtask

  task automatic test_sm_ena_toggle;
    int f0, n; bit ok; wr_t e, o;
    lat_max = 3;
    mem[32'h400] = 32'hABCD_0002; mem[32'h404] = 32'h1234_0003; mem[32'h408] = 32'hFFFF_0004;
    mem[32'h500] = 32'h0007_0005; mem[32'h501] = 32'h8000_0006; mem[32'h502] = 32'h0001_0007;
    model_op(16'h400, 16'h500, 16'h600, 4, 5, 3, 3, 1, 3, 1'b0);
    f0 = req_frozen;
    sm_ena = 1'b1;
    launch(16'h400, 16'h500, 16'h600, 4, 5, 3, 3, 1, 3, 1'b0);
    ok = 1'b0; n = 0;
    while (!ok && n < 600) begin
      @(posedge clk); #1;
      n++;
      if (done) ok = 1'b1;
      if (n % 3 == 0) sm_ena = ~sm_ena;
    end
    sm_ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) $display("FAIL smena_timeout: done not seen"); else passed++;
    checks++; if (req_frozen - f0 !== 0) $display("FAIL smena_req_while_frozen: got %0d want 0", req_frozen - f0); else passed++;
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL smena_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d) $display("FAIL smena_write: got @%h=%0d want @%h=%0d", o.a, o.d, e.a, e.d);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_op;
    bit ok; wr_t e, o;
    lat_max = 3;
    load_2x2();
    launch(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    @(posedge clk); #2;
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== '0) $display("FAIL rstmid_req: got req=%b addr=%h want 0 0", mem_req, mem_addr); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_status: got busy=%b done=%b want 0 0", busy, done); else passed++;
    checks++; if (mem_write !== 1'b0 || mem_wdata !== '0) $display("FAIL rstmid_wr: got wr=%b wdata=%h want 0 0", mem_write, mem_wdata); else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 40 && rd_q.size() > 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_idle_after: got %b want 0", busy); else passed++;
    obs_q.delete(); exp_q.delete();
    model_op(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    launch(16'h100, 16'h200, 16'h300, 2, 2, 2, 2, 2, 2, 1'b0);
    wait_done(400, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ok !== 1'b1) $display("FAIL rstmid_timeout: done not seen"); else passed++;
    checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_nwrites: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.a !== e.a || o.d !== e.d) $display("FAIL rstmid_write: got @%h=%0d want @%h=%0d", o.a, o.d, e.a, e.d);
      else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_random_latency();
    test_acc_mode();
    test_zero_dim();
    test_sm_ena_toggle();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
